// File: rtl/seq01_pkg.sv
// seq01_pkg: shared types and the "01" detector transition function.
// Contents: seq01_state_e (per-channel context), seq01_next(state, x) -> {next, hit}.
// Used by seq01_sched and its arbiter; no ports.
package seq01_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,  // no bit seen since reset
    S_SAW0 = 2'b01,  // last bit was 0
    S_SAW1 = 2'b10   // last bit was 1
  } seq01_state_e;

  // Returns {next[1:0], hit}. The next state depends only on the current bit;
  // a hit needs a preceding 0. Encoding 2'b11 falls into the IDLE behaviour.
  function automatic logic [2:0] seq01_next(input logic [1:0] state, input logic x);
    logic [1:0] nxt;
    logic       hit;
    nxt = x ? S_SAW1 : S_SAW0;
    hit = 1'b0;
    if (state == S_SAW0) begin
      hit = x;
    end
    return {nxt, hit};
  endfunction

endpackage

// File: rtl/seq01_sched_if.sv
// seq01_sched_if: bundles the channel handshake, detection output and counter readback.
// Ports: in_valid/in_bit/in_ready (NCH each), det_valid/det_ch, rd_ch/rd_cnt/clr.
// master = channel sources + event logic side, slave = seq01_sched.
interface seq01_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_bit;
  logic [NCH-1:0] in_ready;
  logic           det_valid;
  logic [CHW-1:0] det_ch;
  logic [CHW-1:0] rd_ch;
  logic [CW-1:0]  rd_cnt;
  logic           clr;

  modport master (
    output in_valid, in_bit, rd_ch, clr,
    input  in_ready, det_valid, det_ch, rd_cnt
  );

  modport slave (
    input  in_valid, in_bit, rd_ch, clr,
    output in_ready, det_valid, det_ch, rd_cnt
  );
endinterface

// File: rtl/seq01_sched_rr_arb.sv
// rr_arb: NCH-wide round-robin arbiter, search starts one past the last granted channel.
// Latency: gnt is combinational from req; the pointer advances on the edge where adv is high.
// Backpressure: a requester that is not granted simply waits; pointer holds without adv.
// Ports: clk, rst (sync, active-high), req[NCH], adv (handshake), gnt[NCH] one-hot or zero.
module rr_arb #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           adv,
  output logic [NCH-1:0] gnt
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CHW-1:0] last_q, last_d;
  logic [CHW-1:0] cand;
  logic           found;
  int             idx;

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    // Walk last+1 .. last+NCH (wrapping) and take the first requester.
    for (int i = 1; i <= NCH; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      cand = CHW'(idx);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        last_d    = cand;
      end
    end
    if (!adv) last_d = last_q;
  end

  // Reset to NCH-1 so channel 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst) last_q <= CHW'(NCH - 1);
    else     last_q <= last_d;
  end
endmodule

// File: rtl/seq01_sched.sv
// seq01_sched: one shared "01" detector time-multiplexed over NCH serial channels.
// Latency: grant same cycle as in_valid; det_valid/det_ch and counters one cycle after acceptance.
// Backpressure: one bit per cycle aggregate; ungranted channels hold in_valid until in_ready.
// Ports: clk, rst (sync, active-high), bus (seq01_sched_if.slave).
// Build option: define SEQ01_SCHED_CNT_EN for per-channel saturating hit counters (rd_cnt, clr);
// otherwise rd_cnt reads 0 and clr is ignored.
module seq01_sched
  import seq01_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq01_sched_if.slave  bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] gnt;
  logic           hs;
  logic [CHW-1:0] sel;
  logic [2:0]     fn_res;

  logic [1:0]     ctx_q [NCH];
  logic [1:0]     ctx_d [NCH];
  logic           det_valid_q, det_valid_d;
  logic [CHW-1:0] det_ch_q, det_ch_d;

  rr_arb #(.NCH(NCH)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.in_valid),
    .adv (hs),
    .gnt (gnt)
  );

  // Grant depends only on in_valid and the pointer, so it is live even during reset.
  assign bus.in_ready = gnt;
  assign hs           = |(bus.in_valid & gnt);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) sel = CHW'(i);
    end
  end

  always_comb begin
    ctx_d       = ctx_q;
    fn_res      = seq01_next(ctx_q[sel], bus.in_bit[sel]);
    det_valid_d = 1'b0;
    det_ch_d    = det_ch_q;
    if (hs) begin
      ctx_d[sel]  = fn_res[2:1];
      det_valid_d = fn_res[0];
      det_ch_d    = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) ctx_q[i] <= S_IDLE;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
    end else begin
      ctx_q       <= ctx_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
    end
  end

  assign bus.det_valid = det_valid_q;
  assign bus.det_ch    = det_ch_q;

`ifdef SEQ01_SCHED_CNT_EN
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];
  logic          rd_ok;

  // rd_ch can address past NCH-1 when NCH is not a power of two.
  assign rd_ok = (int'(bus.rd_ch) < NCH);

  always_comb begin
    cnt_d = cnt_q;
    if (det_valid_d && (cnt_q[sel] != {CW{1'b1}})) begin
      cnt_d[sel] = cnt_q[sel] + 1'b1;
    end
    // Applied last so a clear beats a same-edge hit on the same channel.
    if (bus.clr && rd_ok) begin
      cnt_d[bus.rd_ch] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.rd_cnt = rd_ok ? cnt_q[bus.rd_ch] : '0;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = ^{bus.clr, bus.rd_ch};
  assign bus.rd_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq01_sched.sv
module tb_seq01_sched;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int CMAX = (1 << CW) - 1;

`ifdef SEQ01_SCHED_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq01_sched_if #(.NCH(NCH), .CW(CW)) bus ();
  seq01_sched #(.NCH(NCH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  int cnt_m [NCH];

  typedef struct {
    bit         rst_before;
    logic [3:0] v;
    logic [3:0] b;
    logic [3:0] rdy;
    logic       dv;
    logic [1:0] ch;
  } vec_t;
  vec_t tbl[$];

  typedef struct {
    logic       dv;
    logic [1:0] ch;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input bit r, input logic [3:0] v, input logic [3:0] b,
                     input logic [3:0] rdy, input logic dv, input logic [1:0] ch);
    vec_t e;
    e.rst_before = r; e.v = v; e.b = b; e.rdy = rdy; e.dv = dv; e.ch = ch;
    tbl.push_back(e);
  endtask

  // One bus cycle: drive, check grant, record expectation, clock, compare detection.
  task automatic cyc(input logic [3:0] v, input logic [3:0] b, input logic [3:0] rdy,
                     input logic dv, input logic [1:0] ch, input string nm);
    exp_t e;
    bus.in_valid = v;
    bus.in_bit   = b;
    #1;
    chk({nm, "_rdy"}, 32'(bus.in_ready), 32'(rdy));
    e.dv = dv; e.ch = ch;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (CNT_EN) begin
      if (dv && cnt_m[ch] < CMAX) cnt_m[ch]++;
      if (bus.clr) cnt_m[bus.rd_ch] = 0;
    end
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_dv"}, 32'(bus.det_valid), 32'(e.dv));
      if (e.dv) chk({nm, "_ch"}, 32'(bus.det_ch), 32'(e.ch));
    end
  endtask

  task automatic do_reset(input logic [3:0] v, input logic [3:0] b);
    rst = 1'b1;
    bus.in_valid = v;
    bus.in_bit   = b;
    #1;
    chk("rst_rdy", 32'(bus.in_ready), 32'(v));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dv", 32'(bus.det_valid), 32'd0);
    chk("rst_ch", 32'(bus.det_ch), 32'd0);
    rst = 1'b0;
    bus.in_valid = '0;
    sb.delete();
    for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = '0;
    bus.in_bit   = '0;
    bus.rd_ch    = '0;
    bus.clr      = 1'b0;
    for (int i = 0; i < NCH; i++) cnt_m[i] = 0;

    // ch0 alone: 0,1,1,0,1 -> hits on 2nd and 5th bit.
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 0, 0);
    add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    // All valid: grants rotate; ch2 sends 0 then 1 on its own turns -> one hit tagged 2.
    add(1, 4'b1111, 4'b1001, 4'b0001, 0, 0);
    add(0, 4'b1111, 4'b1001, 4'b0010, 0, 0);
    add(0, 4'b1111, 4'b1001, 4'b0100, 0, 0);
    add(0, 4'b1111, 4'b1001, 4'b1000, 0, 0);
    add(0, 4'b1111, 4'b1101, 4'b0001, 0, 0);
    add(0, 4'b1111, 4'b1101, 4'b0010, 0, 0);
    add(0, 4'b1111, 4'b1101, 4'b0100, 1, 2);
    add(0, 4'b1111, 4'b1101, 4'b1000, 0, 0);
    // Interleave ch1/ch3, then both valid to exercise the rotation pointer.
    add(1, 4'b0010, 4'b0000, 4'b0010, 0, 0);
    add(0, 4'b1000, 4'b1000, 4'b1000, 0, 0);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1);
    add(0, 4'b1010, 4'b0000, 4'b1000, 0, 0);
    add(0, 4'b1010, 4'b0000, 4'b0010, 0, 0);
    add(0, 4'b1010, 4'b1000, 4'b1000, 1, 3);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    do_reset(4'b0000, 4'b0000);
    for (int i = 0; i < NCH; i++) begin
      bus.rd_ch = 2'(i);
      #1;
      chk($sformatf("rst_cnt%0d", i), 32'(bus.rd_cnt), 32'd0);
    end
    bus.rd_ch = '0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset(4'b0000, 4'b0000);
      cyc(tbl[i].v, tbl[i].b, tbl[i].rdy, tbl[i].dv, tbl[i].ch, $sformatf("tbl%0d", i));
    end

    // Reset mid-stream: ch0's earlier 0 and the bit offered during reset are forgotten.
    do_reset(4'b0000, 4'b0000);
    cyc(4'b0001, 4'b0000, 4'b0001, 0, 0, "mid_a");
    do_reset(4'b0001, 4'b0000);
    cyc(4'b0001, 4'b0001, 4'b0001, 0, 0, "mid_b");
    cyc(4'b0001, 4'b0000, 4'b0001, 0, 0, "mid_c");
    cyc(4'b0001, 4'b0001, 4'b0001, 1, 0, "mid_d");
    bus.rd_ch = 2'd0;
    #1;
    chk("mid_cnt", 32'(bus.rd_cnt), 32'(cnt_m[0]));

    // Six 01 pairs on ch1 saturate a 2-bit counter; clear wins over a same-edge hit.
    do_reset(4'b0000, 4'b0000);
    bus.rd_ch = 2'd1;
    for (int k = 1; k <= 6; k++) begin
      cyc(4'b0010, 4'b0000, 4'b0010, 0, 0, $sformatf("sat%0d_0", k));
      cyc(4'b0010, 4'b0010, 4'b0010, 1, 1, $sformatf("sat%0d_1", k));
      chk($sformatf("sat%0d_cnt", k), 32'(bus.rd_cnt), 32'(cnt_m[1]));
    end
    cyc(4'b0010, 4'b0000, 4'b0010, 0, 0, "clr_0");
    bus.clr = 1'b1;
    cyc(4'b0010, 4'b0010, 4'b0010, 1, 1, "clr_hit");
    bus.clr = 1'b0;
    chk("clr_cnt", 32'(bus.rd_cnt), 32'(cnt_m[1]));
    cyc(4'b0010, 4'b0000, 4'b0010, 0, 0, "post_0");
    cyc(4'b0010, 4'b0010, 4'b0010, 1, 1, "post_1");
    chk("post_cnt", 32'(bus.rd_cnt), 32'(cnt_m[1]));
    bus.in_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq01_sched.md
# seq01_sched

Time-multiplexes one shared "01" sequence-detector next-state/output function across NCH independent serial bit channels. A round-robin arbiter accepts at most one bit per cycle. The selected channel's 2-bit context is read from a per-channel state file, advanced through the shared function, and written back. The block sits between the per-channel serial sources and downstream event logic: it reports each detection tagged with its channel and, optionally, keeps per-channel detection counts.

## Interface
- NCH, 4, number of serial channels (2..16)
- CW, 8, detection-counter width (used only when counters are compiled in)
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  NCH  channel i has a bit waiting
- in_bit  in  NCH  serial bit of channel i
- in_ready  out  NCH  one-hot grant; channel i bit consumed when in_valid[i]&in_ready[i]
- det_valid  out  1  registered pulse: a "01" completed on channel det_ch
- det_ch  out  $clog2(NCH)  channel of the current det_valid pulse
- rd_ch  in  $clog2(NCH)  counter readback select
- rd_cnt  out  CW  count of channel rd_ch (0 when counters are compiled out)
- clr  in  1  clear the counter of channel rd_ch

## Operation
- Per-channel context: S_IDLE (no bit since reset), S_SAW0 (last bit 0), S_SAW1 (last bit 1). Encoding 2'b11 is unused; if ever read, treat as S_IDLE.
- Shared function, from (state, x) to (next, hit):
  - IDLE,0 -> SAW0,0
  - IDLE,1 -> SAW1,0
  - SAW0,0 -> SAW0,0
  - SAW0,1 -> SAW1,1
  - SAW1,0 -> SAW0,0
  - SAW1,1 -> SAW1,0
- Overlapping patterns count: bits 0,1,0,1 on one channel give two hits.
- Arbiter: round-robin over channels with in_valid high. Search starts at last_grant+1 modulo NCH. last_grant updates only on a handshake.
- in_ready is combinational from in_valid and last_grant. At most one bit is set, and it is all-zero when no channel is valid.
- Handshake on channel g: context[g] <= next; det_valid <= hit; det_ch <= g.
- No handshake: det_valid <= 0; det_ch holds its value.
- Contexts of ungranted channels are never modified.
- Dropping in_valid without a handshake is legal; the bit is simply not consumed.

## Timing
- Grant is zero-latency; the handshake completes in the same cycle in_valid is seen.
- det_valid/det_ch appear exactly one cycle after the accepting edge. Throughput is one bit per cycle aggregate.
- A continuously valid channel is granted at least once every NCH cycles.
- Reset values:
  - all contexts S_IDLE
  - last_grant = NCH-1, so channel 0 wins first
  - det_valid = 0, det_ch = 0
  - all counters 0
  - in_ready follows in_valid combinationally, even during reset; any handshake during reset is discarded.
- Reset mid-stream discards all history: the first post-reset bit on any channel can never hit.
- Counter update happens on the same edge as the det_valid register load, so rd_cnt reflects a hit one cycle after acceptance.
- Counters saturate at 2^CW-1.
- clr and a hit on the same channel and edge: clear wins, and the counter becomes 0. det_valid still pulses.
- rd_cnt is combinational from rd_ch.

## Configuration
- SEQ01_SCHED_CNT_EN defined: NCH x CW saturating counters, rd_cnt readback and clr are implemented.
- SEQ01_SCHED_CNT_EN undefined:
  - no counter storage
  - rd_cnt is tied to 0 and clr is ignored
  - detection stream behaviour is identical

## Structure
- Package seq01_pkg:
  - state typedef (S_IDLE=2'b00, S_SAW0=2'b01, S_SAW1=2'b10)
  - pure function seq01_next(state, x) returning {next, hit}
- Sub-module rr_arb: NCH-wide round-robin arbiter, with ports clk, rst, req, adv (handshake), gnt (one-hot).
- Context file, output registers and counters live in seq01_sched.

## Test plan
- Reset, then channel 0 alone sends 0,1,1,0,1 -> det_valid pulses one cycle after the 2nd and 5th acceptance, with det_ch=0.
- All four channels are valid continuously -> in_ready cycles 0001, 0010, 0100, 1000, 0001. No channel loses context: ch2 sending 0,1 over its own grants produces exactly one hit tagged 2.
- Interleaving: ch1 sends 0, ch3 sends 1, then ch1 sends 1 -> hit on ch1 only; ch3's context is unchanged.
- Assert rst after ch0 has accepted 0, then ch0 sends 1 -> no hit. A subsequent 0,1 gives a hit; the counter of ch0 reads 1.
- With CW=2, send six "01" pairs on ch1 -> rd_cnt saturates at 3. Pulse clr with rd_ch=1 on a hit edge -> rd_cnt=0 next cycle, and det_valid still pulses.
- Build without SEQ01_SCHED_CNT_EN and rerun the first scenario -> identical det_valid/det_ch trace; rd_cnt stays 0.
